// File: rtl/bounce_gen_pkg.sv
// rtl/bounce_gen_pkg.sv - shared types, constants and LFSR step for the bounce generator
package bounce_gen_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // One step of a right-shifting Galois LFSR
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, reusable by stimulus blocks
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    // An all-zero state would lock the LFSR, so substitute 1
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state_q;

    // Advance every cycle; reset reloads the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= lfsr_next(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/bounce_generator.sv
// rtl/bounce_generator.sv - bouncy button waveform source; BOUNCE_GEN_STATS_EN adds edge_total
module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int          BOUNCE_TICKS = 50,
    parameter int          MAX_GLITCHES = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    localparam int         GC_W         = (MAX_GLITCHES > 0) ? $clog2(MAX_GLITCHES + 1) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    input  logic            cmd_level,
    output logic            cmd_ready,
    output logic            button_out,
    output logic            busy,
    output logic            settled,
    output logic [GC_W-1:0] glitch_count
`ifdef BOUNCE_GEN_STATS_EN
    ,
    output logic [15:0]     edge_total
`endif
);

    localparam int              CNT_W  = $clog2(BOUNCE_TICKS);
    localparam logic [GC_W-1:0] GC_MAX = GC_W'(MAX_GLITCHES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GC_W-1:0]  gc_q, gc_d;
    logic             btn_q, btn_d;
    logic             target_q, target_d;
    logic             same_q, same_d;
    logic [15:0]      lfsr_state;
    logic             unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .state_o(lfsr_state)
    );

    // Only the low bits pick glitch cycles
    assign unused_lfsr_hi = ^lfsr_state[15:3];

    // Next-state: accept in IDLE, random glitches in BOUNCE, forced final level on the last tick
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gc_d     = gc_q;
        btn_d    = btn_q;
        target_d = target_q;
        same_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    gc_d = '0;
                    if (cmd_level != btn_q) begin
                        btn_d    = cmd_level;
                        target_d = cmd_level;
                        cnt_d    = CNT_W'(BOUNCE_TICKS - 1);
                        state_d  = BOUNCE;
                    end else begin
                        same_d = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    btn_d   = target_q;
                    state_d = SETTLE;
                end else if (lfsr_state[2:0] == 3'b000 && gc_q != GC_MAX) begin
                    btn_d = ~btn_q;
                    gc_d  = gc_q + 1'b1;
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gc_q     <= '0;
            btn_q    <= 1'b0;
            target_q <= 1'b0;
            same_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gc_q     <= gc_d;
            btn_q    <= btn_d;
            target_q <= target_d;
            same_q   <= same_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q == BOUNCE);
    assign settled      = (state_q == SETTLE) || same_q;
    assign button_out   = btn_q;
    assign glitch_count = gc_q;

`ifdef BOUNCE_GEN_STATS_EN
    logic [15:0] edge_q;

    // Count every output toggle, forced or glitch, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= '0;
        end else if (btn_d != btn_q && edge_q != 16'hFFFF) begin
            edge_q <= edge_q + 16'd1;
        end
    end

    assign edge_total = edge_q;
`endif

endmodule

// File: tb/tb_bounce_generator.sv
// tb/tb_bounce_generator.sv - scoreboard bench for bounce_generator (glitchy and clean instances)
module tb_bounce_generator;

    localparam int          BT   = 50;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int gc;
        int edges;
        int busy;
        int scyc;
        int rdy;
        int level;
        int tot_snap;
        int busy_snap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
    logic       r0, b0, busy0, s0, r1, b1, busy1, s1;
    logic [0:0] gc0;
    logic [3:0] gc1;
`ifdef BOUNCE_GEN_STATS_EN
    logic [15:0] et0, et1;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    int   tot0 = 0, tot1 = 0, busyt0 = 0, busyt1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0, after0 = 1'b0, after1 = 1'b0;
    logic cur0 = 1'b0, cur1 = 1'b0;
    logic [15:0] m_lfsr;
    logic [3:0]  gc_hold;

    bounce_generator #(.BOUNCE_TICKS(BT), .MAX_GLITCHES(0), .LFSR_SEED(SEED)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_level(l0), .cmd_ready(r0),
        .button_out(b0), .busy(busy0), .settled(s0), .glitch_count(gc0)
`ifdef BOUNCE_GEN_STATS_EN
        , .edge_total(et0)
`endif
    );

    bounce_generator #(.BOUNCE_TICKS(BT), .MAX_GLITCHES(8), .LFSR_SEED(SEED)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_level(l1), .cmd_ready(r1),
        .button_out(b1), .busy(busy1), .settled(s1), .glitch_count(gc1)
`ifdef BOUNCE_GEN_STATS_EN
        , .edge_total(et1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= step(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input logic [15:0] lf, input logic cur, input logic tgt,
                                     input int maxg, input int acc, input int ts, input int bs);
        exp_t e;
        logic [15:0] l;
        int g;
        l = lf;
        g = 0;
        e.tot_snap  = ts;
        e.busy_snap = bs;
        e.level     = int'(tgt);
        if (cur == tgt) begin
            e.gc = 0; e.edges = 0; e.busy = 0; e.scyc = acc; e.rdy = 1;
        end else begin
            for (int j = 1; j <= BT - 2; j++) begin
                l = step(l);
                if (l[2:0] == 3'b000 && g < maxg) g++;
            end
            e.gc = g; e.edges = 1 + g + (g % 2); e.busy = BT - 1; e.scyc = acc + BT - 1; e.rdy = 0;
        end
        return e;
    endfunction

    task automatic settle_chk(input string d, input exp_t e, input int gc, input int tot,
                              input int bt, input int c, input logic lvl, input logic rdy);
        check({d, "_glitch_count"}, gc, e.gc);
        check({d, "_edges"}, tot - e.tot_snap, e.edges);
        check({d, "_busy_cycles"}, bt - e.busy_snap, e.busy);
        check({d, "_settle_cycle"}, c, e.scyc);
        check({d, "_level"}, {31'd0, lvl}, e.level);
        check({d, "_ready_in_settle"}, {31'd0, rdy}, e.rdy);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            tot0 = 0; busyt0 = 0; prev0 = 1'b0; after0 = 1'b0;
            tot1 = 0; busyt1 = 0; prev1 = 1'b0; after1 = 1'b0;
        end else begin
            if (b0 !== prev0) tot0++;
            if (b1 !== prev1) tot1++;
            prev0 = b0;
            prev1 = b1;
            if (busy0) busyt0++;
            if (busy1) busyt1++;
            if (after0) begin
                check("d0_ready_after_settle", {31'd0, r0}, 1);
                check("d0_busy_after_settle", {31'd0, busy0}, 0);
                after0 = 1'b0;
            end
            if (after1) begin
                check("d1_ready_after_settle", {31'd0, r1}, 1);
                check("d1_busy_after_settle", {31'd0, busy1}, 0);
                after1 = 1'b0;
            end
            if (s0) begin
                if (sb0.size() == 0) check("d0_unexpected_settled", 1, 0);
                else begin
                    e0 = sb0.pop_front();
                    settle_chk("d0", e0, int'(gc0), tot0, busyt0, cyc, b0, r0);
                end
                after0 = 1'b1;
            end
            if (s1) begin
                if (sb1.size() == 0) check("d1_unexpected_settled", 1, 0);
                else begin
                    e1 = sb1.pop_front();
                    settle_chk("d1", e1, int'(gc1), tot1, busyt1, cyc, b1, r1);
                end
                after1 = 1'b1;
            end
        end
    end

    task automatic send(input int id, input logic lvl);
        int w;
        w = 0;
        @(negedge clk); #1;
        while (((id == 0) ? (!r0 || sb0.size() != 0 || after0)
                          : (!r1 || sb1.size() != 0 || after1)) && w < 300) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 300) check("send_timeout", 0, 1);
        if (id == 0) begin
            sb0.push_back(predict(m_lfsr, cur0, lvl, 0, cyc + 1, tot0, busyt0));
            cur0 = lvl;
            v0 = 1'b1; l0 = lvl;
            @(negedge clk); #1;
            v0 = 1'b0;
        end else begin
            sb1.push_back(predict(m_lfsr, cur1, lvl, 8, cyc + 1, tot1, busyt1));
            cur1 = lvl;
            v1 = 1'b1; l1 = lvl;
            @(negedge clk); #1;
            v1 = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || after0 || after1) && w < 500) begin
            @(negedge clk); #1;
            w++;
        end
        if (w >= 500) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("d1_idle_outputs", {28'd0, b1, r1, busy1, s1}, 32'b0100);
            check("d0_idle_outputs", {28'd0, b0, r0, busy0, s0}, 32'b0100);
        end
`ifdef BOUNCE_GEN_STATS_EN
        check("d0_edge_total_idle", et0, 0);
        check("d1_edge_total_idle", et1, 0);
`endif

        for (int i = 0; i < 10; i++) begin
            send(0, ~cur0);
            repeat ($urandom_range(227, 100)) @(negedge clk);
        end
        drain();
`ifdef BOUNCE_GEN_STATS_EN
        check("d0_edge_total_10", et0, 10);
`endif

        send(1, 1'b1);
        send(1, 1'b0);
        send(1, 1'b1);
        send(1, 1'b1);
        send(1, 1'b0);
        send(1, 1'b1);
        drain();
        gc_hold = gc1;
        repeat (30) @(negedge clk);
        check("d1_glitch_count_hold", gc1, gc_hold);

        send(1, 1'b0);
        drain();
        send(1, 1'b1);
        repeat (10) @(negedge clk);
        #1 v1 = 1'b1; l1 = 1'b0;
        @(negedge clk);
        #1 v1 = 1'b0;
        drain();
        check("d1_level_after_ignored_cmd", {31'd0, b1}, 1);

        send(1, 1'b0);
        send(1, 1'b1);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_button_out", {31'd0, b1}, 0);
        check("rst_glitch_count", gc1, 0);
        check("rst_busy", {31'd0, busy1}, 0);
        check("rst_cmd_ready", {31'd0, r1}, 1);
        sb1.delete();
        sb0.delete();
        cur1 = 1'b0;
        cur0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_settled", {30'd0, s1, s0}, 0);
        end
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_settled", {31'd0, s1}, 0);
        end

        send(1, 1'b1);
        send(1, 1'b0);
        send(0, 1'b1);
        drain();
`ifdef BOUNCE_GEN_STATS_EN
        check("d1_edge_total", et1, tot1);
        check("d0_edge_total_post_rst", et0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
